// File: rtl/corr_peak_detector_pkg.sv
// Shared correlation definitions: detector states, tdata field layout, magnitude width.
// Imported by corr_peak_detector and its testbench.
package corr_peak_detector_pkg;

  localparam int TDATA_W = 32;
  localparam int COMP_W  = 16;
  localparam int RE_LSB  = 0;
  localparam int IM_LSB  = 16;
  localparam int MAG_W   = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } corr_state_t;

  typedef logic [MAG_W-1:0] mag_t;

endpackage

// File: rtl/corr_peak_detector.sv
// Finds max |re|+|im| and its beat index over a frame; result pulses 3 edges after the last beat.
// corr_tready is high only in RUN, so upstream stalls freely via corr_tvalid and is held off outside a frame.
module corr_peak_detector
  import corr_peak_detector_pkg::*;
#(
  parameter int LEN_W = 14
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [LEN_W-1:0]   frame_len,
  input  logic               start,
  output logic               idle,
  input  logic [TDATA_W-1:0] corr_tdata,
  input  logic               corr_tvalid,
  output logic               corr_tready,
  output logic [MAG_W-1:0]   peak_mag,
  output logic [LEN_W-1:0]   peak_index,
  output logic               peak_valid
);

  corr_state_t      state;
  corr_state_t      state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             flush_cnt;
  logic             accept;
  logic             last_beat;
  logic             start_ok;

  logic             s1_vld;
  mag_t             s1_mag;
  logic [LEN_W-1:0] s1_idx;
  mag_t             run_max;
  logic [LEN_W-1:0] run_idx;

  // Sign-extend before negating so that -32768 becomes +32768 instead of wrapping.
  function automatic mag_t abs_comp(input logic [COMP_W-1:0] v);
    mag_t ext;
    ext = {v[COMP_W-1], v};
    return v[COMP_W-1] ? (~ext + mag_t'(1)) : ext;
  endfunction

  function automatic mag_t beat_mag(input logic [TDATA_W-1:0] d);
    return abs_comp(d[RE_LSB +: COMP_W]) + abs_comp(d[IM_LSB +: COMP_W]);
  endfunction

  assign idle        = (state == ST_IDLE);
  assign corr_tready = (state == ST_RUN);
  assign accept      = corr_tvalid & corr_tready;
  assign last_beat   = accept && (cnt == len_q - LEN_W'(1));
  assign start_ok    = idle & start;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)     state_nxt = (frame_len == '0) ? ST_FLUSH : ST_RUN;
      ST_RUN:   if (last_beat) state_nxt = ST_FLUSH;
      ST_FLUSH: if (flush_cnt) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      len_q      <= '0;
      cnt        <= '0;
      flush_cnt  <= 1'b0;
      s1_vld     <= 1'b0;
      s1_mag     <= '0;
      s1_idx     <= '0;
      run_max    <= '0;
      run_idx    <= '0;
      peak_mag   <= '0;
      peak_index <= '0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= 1'b0;

      // Stage 1: magnitude of the accepted beat, tagged with its index.
      s1_vld <= accept;
      if (accept) begin
        s1_mag <= beat_mag(corr_tdata);
        s1_idx <= cnt;
        cnt    <= cnt + LEN_W'(1);
      end

      // Stage 2: strict compare keeps the first occurrence on ties.
      if (start_ok) begin
        len_q   <= frame_len;
        cnt     <= '0;
        run_max <= '0;
        run_idx <= '0;
      end else if (s1_vld && (s1_mag > run_max)) begin
        run_max <= s1_mag;
        run_idx <= s1_idx;
      end

      // Two FLUSH cycles let the last beat drain through both stages.
      if (state == ST_FLUSH) begin
        flush_cnt <= ~flush_cnt;
      end else begin
        flush_cnt <= 1'b0;
      end

      if ((state == ST_FLUSH) && flush_cnt) begin
        peak_valid <= 1'b1;
        peak_mag   <= run_max;
        peak_index <= run_idx;
      end
    end
  end

endmodule

// File: tb/tb_corr_peak_detector.sv
// Directed self-checking bench for corr_peak_detector: frames, ties, extremes, backpressure, edge starts, reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_corr_peak_detector;

  localparam int LEN_W = 14;

  logic             aclk = 1'b0;
  logic             areset;
  logic [LEN_W-1:0] frame_len;
  logic             start;
  logic             idle;
  logic [31:0]      corr_tdata;
  logic             corr_tvalid;
  logic             corr_tready;
  logic [16:0]      peak_mag;
  logic [LEN_W-1:0] peak_index;
  logic             peak_valid;

  int checks = 0;
  int errors = 0;
  logic [31:0] beats [0:299];

  always #5 aclk = ~aclk;

  corr_peak_detector #(.LEN_W(LEN_W)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .frame_len  (frame_len),
    .start      (start),
    .idle       (idle),
    .corr_tdata (corr_tdata),
    .corr_tvalid(corr_tvalid),
    .corr_tready(corr_tready),
    .peak_mag   (peak_mag),
    .peak_index (peak_index),
    .peak_valid (peak_valid)
  );

  task automatic tick;
    @(negedge aclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] pk(input int re, input int im);
    logic [31:0] r;
    r = {im[15:0], re[15:0]};
    return r;
  endfunction

  function automatic int ref_mag(input logic [31:0] d);
    int re;
    int im;
    re = int'($signed(d[15:0]));
    im = int'($signed(d[31:16]));
    if (re < 0) re = -re;
    if (im < 0) im = -im;
    return re + im;
  endfunction

  // Starts a frame of n beats from beats[], optionally with tvalid gaps and a
  // stray start mid-frame; returns on the falling edge of the peak_valid cycle.
  task automatic do_frame(input string tag, input int n, input bit gaps, input bit mid_start,
                          input int exp_mag, input int exp_idx);
    int i;
    int acc;
    int cyc;
    start       = 1'b1;
    frame_len   = n[LEN_W-1:0];
    corr_tvalid = 1'b0;
    tick;
    start     = 1'b0;
    frame_len = LEN_W'(n + 3);
    chk({tag, " tready_after_start"}, 32'(corr_tready), 32'(n != 0));
    chk({tag, " idle_after_start"}, 32'(idle), 32'd0);
    i   = 0;
    acc = 0;
    cyc = 0;
    while (i < n && cyc < 4000) begin
      corr_tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      corr_tdata  = beats[i];
      if (mid_start && i == 1) begin
        start     = 1'b1;
        frame_len = LEN_W'(7);
      end else begin
        start = 1'b0;
      end
      if (corr_tvalid && corr_tready) begin
        i++;
        acc++;
      end
      tick;
      cyc++;
    end
    start = 1'b0;
    chk({tag, " beats_in_budget"}, i, n);
    corr_tvalid = 1'b1;
    corr_tdata  = 32'h7fff7fff;
    chk({tag, " tready_after_last"}, 32'(corr_tready), 32'd0);
    chk({tag, " pv_edge1"}, 32'(peak_valid), 32'd0);
    if (corr_tready) acc++;
    tick;
    chk({tag, " pv_edge2"}, 32'(peak_valid), 32'd0);
    if (corr_tready) acc++;
    tick;
    corr_tvalid = 1'b0;
    chk({tag, " pv_edge3"}, 32'(peak_valid), 32'd1);
    chk({tag, " idle_on_pv"}, 32'(idle), 32'd1);
    chk({tag, " peak_mag"}, 32'(peak_mag), exp_mag);
    chk({tag, " peak_index"}, 32'(peak_index), exp_idx);
    chk({tag, " accepted"}, acc, n);
  endtask

  initial begin
    int em;
    int ei;
    int m;
    areset      = 1'b1;
    start       = 1'b0;
    frame_len   = '0;
    corr_tvalid = 1'b0;
    corr_tdata  = '0;
    tick;
    tick;
    chk("rst idle", 32'(idle), 32'd1);
    chk("rst tready", 32'(corr_tready), 32'd0);
    chk("rst peak_valid", 32'(peak_valid), 32'd0);
    chk("rst peak_mag", 32'(peak_mag), 32'd0);
    chk("rst peak_index", 32'(peak_index), 32'd0);
    areset = 1'b0;
    tick;

    beats[0] = pk(1, 1);
    beats[1] = pk(-100, 3);
    beats[2] = pk(50, -60);
    beats[3] = pk(0, 0);
    beats[4] = pk(7, 7);
    do_frame("basic", 5, 1'b0, 1'b0, 110, 2);
    tick;
    chk("basic pv_one_cycle", 32'(peak_valid), 32'd0);
    chk("basic mag_held", 32'(peak_mag), 32'd110);
    chk("basic idx_held", 32'(peak_index), 32'd2);

    beats[0] = pk(4, 5);
    beats[1] = pk(20, 0);
    beats[2] = pk(-10, 10);
    beats[3] = pk(0, -5);
    do_frame("tie", 4, 1'b0, 1'b0, 20, 1);

    // Each of the next frames starts on the previous frame's peak_valid cycle.
    beats[0] = pk(-32768, -32768);
    do_frame("extreme", 1, 1'b0, 1'b0, 65536, 0);
    do_frame("zero_len", 0, 1'b0, 1'b0, 0, 0);

    beats[0] = pk(3, 3);
    beats[1] = pk(-5, 0);
    beats[2] = pk(0, 9);
    beats[3] = pk(2, -2);
    beats[4] = pk(-8, -1);
    beats[5] = pk(1, 0);
    do_frame("run_start", 6, 1'b0, 1'b1, 9, 2);
    tick;

    em = 0;
    ei = 0;
    for (int k = 0; k < 300; k++) begin
      beats[k] = pk(int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200);
      m = ref_mag(beats[k]);
      if (m > em) begin
        em = m;
        ei = k;
      end
    end
    do_frame("backpressure", 300, 1'b1, 1'b0, em, ei);
    tick;
    chk("backpressure pv_one_cycle", 32'(peak_valid), 32'd0);

    start     = 1'b1;
    frame_len = LEN_W'(20);
    tick;
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      corr_tvalid = 1'b1;
      corr_tdata  = pk(k + 1, 0);
      tick;
    end
    areset = 1'b1;
    tick;
    areset = 1'b0;
    chk("midrst idle", 32'(idle), 32'd1);
    chk("midrst tready", 32'(corr_tready), 32'd0);
    chk("midrst peak_valid", 32'(peak_valid), 32'd0);
    chk("midrst peak_mag", 32'(peak_mag), 32'd0);
    chk("midrst peak_index", 32'(peak_index), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("midrst tready_hold", 32'(corr_tready), 32'd0);
      chk("midrst no_pv", 32'(peak_valid), 32'd0);
    end
    corr_tvalid = 1'b0;

    beats[0] = pk(2, 2);
    beats[1] = pk(-6, 1);
    beats[2] = pk(3, -3);
    do_frame("after_reset", 3, 1'b0, 1'b0, 7, 1);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/corr_peak_detector.md
CORR_PEAK_DETECTOR -- requirements
Module: corr_peak_detector

Interface
REQ-001 SHALL have parameter LEN_W, default 14, giving the frame-length and index width (covers N1+N2-1 up to 16381).
REQ-002 SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port areset, input, 1, a synchronous, active-high reset.
REQ-004 SHALL have port frame_len, input, LEN_W, the number of correlation beats in one frame, sampled on start.
REQ-005 SHALL have port start, input, 1, which begins a frame when the block is idle.
REQ-006 SHALL have port idle, output, 1, high when no frame is in progress.
REQ-007 SHALL have port corr_tdata, input, 32, correlation sample: [15:0] signed real part, [31:16] signed imaginary part.
REQ-008 SHALL have port corr_tvalid, input, 1, AXI-Stream valid.
REQ-009 SHALL have port corr_tready, output, 1, AXI-Stream ready.
REQ-010 SHALL have port peak_mag, output, 17, maximum of |re|+|im| over the frame.
REQ-011 SHALL have port peak_index, output, LEN_W, 0-based beat index of that maximum.
REQ-012 SHALL have port peak_valid, output, 1, a one-cycle pulse marking the result as complete.

Function
REQ-013 SHALL implement the states IDLE, RUN and FLUSH.
REQ-014 SHALL, in IDLE with start=1, latch frame_len, clear the beat counter and the running max/index, and go to RUN; if frame_len=0 it SHALL go to FLUSH instead.
REQ-015 SHALL drive corr_tready = (state==RUN), combinationally from the state register only, independent of corr_tvalid.
REQ-016 SHALL count a beat only when corr_tvalid & corr_tready; tvalid low stalls the counter without losing data.
REQ-017 SHALL leave RUN for FLUSH on the edge that accepts beat number frame_len-1; corr_tready is low in the following cycle.
REQ-018 SHALL use a 2-stage pipeline. Stage 1 registers mag = |re|+|im| in 17 bits, with |-32768| = 32768 and no saturation. Stage 2 compares mag against the running max.
REQ-019 SHALL update the running max and index only when mag is strictly greater than the max, so that on ties the first occurrence wins; the index is the beat count at acceptance.
REQ-020 SHALL hold FLUSH for exactly 2 cycles, then return to IDLE and assert peak_valid for 1 cycle; peak_valid therefore rises 3 edges after the final beat is accepted.
REQ-021 SHALL hold peak_mag and peak_index stable from the peak_valid cycle until the next accepted start; a frame_len=0 frame reports mag 0, index 0.
REQ-022 SHALL drive idle = (state==IDLE), which includes the peak_valid cycle.
REQ-023 SHALL ignore start while in RUN or FLUSH; the latched frame_len is unaffected by later changes to the port.
REQ-024 SHALL accept a start asserted in the same cycle as peak_valid, which begins the next frame.

Reset
REQ-025 SHALL, when areset=1 at a rising edge, force: state IDLE, idle=1, corr_tready=0, peak_valid=0, peak_mag=0, peak_index=0, counter 0, pipeline valid bits 0.
REQ-026 SHALL, on reset mid-frame, abort the frame with no peak_valid pulse; beats presented afterwards are not accepted until a new start.

Structure
REQ-027 SHALL take the state enumeration, the tdata field offsets (RE_LSB=0, IM_LSB=16) and MAG_W=17 from the shared correlation package.
REQ-028 SHALL be a single module with no sub-modules; the magnitude stage may be a local function.

Verification
REQ-029 SHALL cover the basic frame: frame_len=5 with beats (re,im) = (1,1), (-100,3), (50,-60), (0,0), (7,7), tvalid always 1 -> peak_mag=110, peak_index=2, peak_valid exactly 3 cycles after the 5th beat.
REQ-030 SHALL cover ties: frame_len=4 with magnitudes 9, 20, 20, 5 -> peak_index=1, peak_mag=20.
REQ-031 SHALL cover the extreme sample: one beat (-32768,-32768), frame_len=1 -> peak_mag=65536, peak_index=0.
REQ-032 SHALL cover backpressure: random tvalid gaps over frame_len=300 -> result matches the reference model; exactly 300 beats accepted; tready low after the last beat.
REQ-033 SHALL cover edge starts: frame_len=0 -> peak_valid 3 cycles after start with mag 0; start during RUN ignored; start on the peak_valid cycle begins a new frame.
REQ-034 SHALL cover reset mid-frame: areset after 10 of 20 beats -> all outputs at reset values, no peak_valid; a following 3-beat frame reports correct results.
